// File: rtl/dmem_block_responder.sv
// Data-memory responder: zero-wait word reads/writes plus fixed-latency 256-bit line transfers.
// Defining DMEM_PERF_CNT_EN adds saturating block-read/block-write/wait-cycle counters.
module dmem_block_responder #(
    parameter int LINE_IDX_W = 10,
    parameter int LATENCY    = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  data_address_2DM,
    input  logic         MemRead_2DM,
    input  logic         MemWrite_2DM,
    input  logic [31:0]  data_write_2DM,
    input  logic [1:0]   data_write_size_2DM,
    output logic [31:0]  data_read_fDM,
    input  logic         dBlkRead,
    input  logic         dBlkWrite,
    input  logic [255:0] block_write_2DM,
    output logic [255:0] block_read_fDM,
    output logic         block_read_fDM_valid,
    output logic         block_write_fDM_valid
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]  perf_blk_reads,
    output logic [31:0]  perf_blk_writes,
    output logic [31:0]  perf_wait_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

    stateT                 state, nextState;
    logic [7:0]            cnt, nextCnt;
    logic                  start;
    logic                  isWrite;
    logic [LINE_IDX_W-1:0] lineIdx;
    logic [255:0]          blkData;

    logic [255:0]          mem [0:(2**LINE_IDX_W)-1];
    logic [LINE_IDX_W-1:0] addrLine;
    logic [2:0]            addrWord;
    logic [255:0]          curLine;
    logic [255:0]          mergedLine;
    logic [31:0]           rdWord;
    logic                  commit;
    logic                  unusedOk;

    // Big-endian byte lane merge; bytes that would spill past the word are dropped.
    function automatic logic [255:0] mergeWord(input logic [255:0] line,
                                               input logic [4:0]   byteOff,
                                               input logic [1:0]   size,
                                               input logic [31:0]  data);
        logic [255:0] res;
        logic [31:0]  sh;
        int           nBytes;
        int           lane;
        res    = line;
        nBytes = (size == 2'd0) ? 4 : int'(size);
        for (int b = 0; b < 32; b++) begin
            lane = b - int'(byteOff);
            if (lane >= 0 && lane < nBytes && (b / 4) == int'(byteOff[4:2])) begin
                sh = data >> (8 * (nBytes - 1 - lane));
                res[255 - 8*b -: 8] = sh[7:0];
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign addrLine = data_address_2DM[LINE_IDX_W+4:5];
    assign addrWord = data_address_2DM[4:2];
    assign curLine  = mem[addrLine];
    assign unusedOk = &{1'b0, MemRead_2DM, data_address_2DM[31:LINE_IDX_W+5]};

    always_comb begin
        rdWord = '0;
        for (int k = 0; k < 8; k++) begin
            if (addrWord == 3'(k)) rdWord = curLine[255 - 32*k -: 32];
        end
    end

    assign data_read_fDM = rdWord;
    assign mergedLine    = mergeWord(curLine, data_address_2DM[4:0],
                                     data_write_size_2DM, data_write_2DM);
    assign commit        = (state == DONE) && isWrite;

    assign block_read_fDM_valid  = (state == DONE) && !isWrite;
    assign block_write_fDM_valid = (state == DONE) && isWrite;

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (dBlkWrite || dBlkRead) begin
                    nextState = WAIT;
                    nextCnt   = 8'(LATENCY);
                    start     = 1'b1;
                end
            end
            WAIT: begin
                if (cnt == 8'd0) nextState = DONE;
                else             nextCnt   = cnt - 8'd1;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            isWrite        <= 1'b0;
            block_read_fDM <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            if (start) isWrite <= dBlkWrite;
            // Read data is captured from the array as it stands when DONE is entered.
            if (state == WAIT && cnt == 8'd0 && !isWrite) block_read_fDM <= mem[lineIdx];
        end
    end

    always_ff @(posedge CLK) begin
        if (start) begin
            lineIdx <= addrLine;
            if (dBlkWrite) blkData <= block_write_2DM;
        end
    end

    // The block commit is issued last so it overrides a same-edge word write to that line.
    always_ff @(posedge CLK) begin
        if (MemWrite_2DM) mem[addrLine] <= mergedLine;
        if (commit)       mem[lineIdx]  <= blkData;
    end

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            perf_blk_reads   <= '0;
            perf_blk_writes  <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (state == DONE && !isWrite) perf_blk_reads  <= satInc(perf_blk_reads);
            if (state == DONE && isWrite)  perf_blk_writes <= satInc(perf_blk_writes);
            if (state == WAIT)             perf_wait_cycles <= satInc(perf_wait_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_block_responder.sv
// Randomized bench for dmem_block_responder against a byte-array reference model.
// Two instances: LATENCY=4 for the main checks, LATENCY=0 for zero-latency timing and aliasing.
module tb_dmem_block_responder;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstN;
    logic [31:0]  addr, wData, rData;
    logic         memRd, memWr, blkRdReq, blkWrReq, rValid, wValid;
    logic [1:0]   wSize;
    logic [255:0] blkWr, blkRd;

    logic [31:0]  addrB, rDataB;
    logic         blkRdReqB, blkWrReqB, rValidB, wValidB;
    logic [255:0] blkWrB, blkRdB;
    logic         memWrB;
    logic [31:0]  wDataB;
    logic [1:0]   wSizeB;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0]  perfReads, perfWrites, perfWaits;
    logic [31:0]  perfReadsB, perfWritesB, perfWaitsB;
`endif

    dmem_block_responder #(.LINE_IDX_W(10), .LATENCY(LAT)) dut (
        .CLK(clk), .RESET(rstN), .data_address_2DM(addr), .MemRead_2DM(memRd),
        .MemWrite_2DM(memWr), .data_write_2DM(wData), .data_write_size_2DM(wSize),
        .data_read_fDM(rData), .dBlkRead(blkRdReq), .dBlkWrite(blkWrReq),
        .block_write_2DM(blkWr), .block_read_fDM(blkRd),
        .block_read_fDM_valid(rValid), .block_write_fDM_valid(wValid)
`ifdef DMEM_PERF_CNT_EN
        , .perf_blk_reads(perfReads), .perf_blk_writes(perfWrites), .perf_wait_cycles(perfWaits)
`endif
    );

    dmem_block_responder #(.LINE_IDX_W(10), .LATENCY(0)) dutB (
        .CLK(clk), .RESET(rstN), .data_address_2DM(addrB), .MemRead_2DM(1'b0),
        .MemWrite_2DM(memWrB), .data_write_2DM(wDataB), .data_write_size_2DM(wSizeB),
        .data_read_fDM(rDataB), .dBlkRead(blkRdReqB), .dBlkWrite(blkWrReqB),
        .block_write_2DM(blkWrB), .block_read_fDM(blkRdB),
        .block_read_fDM_valid(rValidB), .block_write_fDM_valid(wValidB)
`ifdef DMEM_PERF_CNT_EN
        , .perf_blk_reads(perfReadsB), .perf_blk_writes(perfWritesB), .perf_wait_cycles(perfWaitsB)
`endif
    );

    int checks, failures;
    int mReads, mWrites, mWaits;
    logic [255:0] lastRead;
    logic [7:0]   mBytes [0:32767];

    task automatic checkVal(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] modelLine(input logic [31:0] a);
        logic [255:0] r;
        int base;
        base = int'(a[14:5]) * 32;
        r = '0;
        for (int b = 0; b < 32; b++) r = {r[247:0], mBytes[base + b]};
        return r;
    endfunction

    function automatic logic [31:0] modelWord(input logic [31:0] a);
        int base;
        base = int'(a[14:2]) * 4;
        return {mBytes[base], mBytes[base+1], mBytes[base+2], mBytes[base+3]};
    endfunction

    task automatic modelBlkWrite(input logic [31:0] a, input logic [255:0] d);
        int base;
        base = int'(a[14:5]) * 32;
        for (int b = 0; b < 32; b++) mBytes[base + b] = d[255 - 8*b -: 8];
    endtask

    function automatic logic [255:0] randLine();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], $urandom()};
        return r;
    endfunction

    task automatic wordWrite(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int n, off;
        logic [31:0] sh;
        @(negedge clk);
        addr = a; wData = d; wSize = sz; memWr = 1'b1;
        @(negedge clk);
        memWr = 1'b0;
        n   = (sz == 2'd0) ? 4 : int'(sz);
        off = int'(a[1:0]);
        for (int i = 0; i < n; i++) begin
            if (off + i < 4) begin
                sh = d >> (8 * (n - 1 - i));
                mBytes[int'(a[14:0]) + i] = sh[7:0];
            end
        end
    endtask

    task automatic wordCheck(input string tag, input logic [31:0] a);
        @(negedge clk);
        addr = a;
        #1;
        checkVal(tag, rData, modelWord(a));
    endtask

    task automatic blkOp(input bit isW, input logic [31:0] a, input logic [255:0] d, input string tag);
        int k;
        bit seen;
        logic [255:0] expRd;
        @(negedge clk);
        addr = a; blkWr = d;
        if (isW) blkWrReq = 1'b1; else blkRdReq = 1'b1;
        expRd = modelLine(a);
        k = 0; seen = 0;
        while (!seen && k < LAT + 10) begin
            @(negedge clk);
            k++;
            if (isW ? wValid : rValid) seen = 1;
        end
        checkVal({tag, "_lat"}, 256'(k), 256'(LAT + 2));
        checkVal({tag, "_other"}, 256'(isW ? rValid : wValid), 256'(0));
        if (!isW) begin
            checkVal({tag, "_rdata"}, blkRd, expRd);
            lastRead = expRd;
            mReads++;
        end else begin
            modelBlkWrite(a, d);
            mWrites++;
        end
        mWaits += LAT + 1;
        blkWrReq = 1'b0; blkRdReq = 1'b0;
        @(negedge clk);
        checkVal({tag, "_pulse"}, 256'(isW ? wValid : rValid), 256'(0));
        if (isW) checkVal({tag, "_hold"}, blkRd, lastRead);
    endtask

    task automatic blkOpB(input bit isW, input logic [31:0] a, input logic [255:0] d,
                          input logic [255:0] expRd, input string tag);
        int k;
        bit seen;
        @(negedge clk);
        addrB = a; blkWrB = d;
        if (isW) blkWrReqB = 1'b1; else blkRdReqB = 1'b1;
        k = 0; seen = 0;
        while (!seen && k < 10) begin
            @(negedge clk);
            k++;
            if (isW ? wValidB : rValidB) seen = 1;
        end
        checkVal({tag, "_lat"}, 256'(k), 256'(2));
        if (!isW) checkVal({tag, "_rdata"}, blkRdB, expRd);
        blkWrReqB = 1'b0; blkRdReqB = 1'b0;
        @(negedge clk);
        checkVal({tag, "_pulse"}, 256'(isW ? wValidB : rValidB), 256'(0));
    endtask

    initial begin
        logic [255:0] p, q;
        logic [31:0]  a;
        int k;
        bit anyV;
        checks = 0; failures = 0;
        mReads = 0; mWrites = 0; mWaits = 0;
        lastRead = '0;
        rstN = 1'b0;
        addr = '0; wData = '0; wSize = '0; memRd = 1'b0; memWr = 1'b0;
        blkRdReq = 1'b0; blkWrReq = 1'b0; blkWr = '0;
        addrB = '0; wDataB = '0; wSizeB = '0; memWrB = 1'b0;
        blkRdReqB = 1'b0; blkWrReqB = 1'b0; blkWrB = '0;
        repeat (2) @(negedge clk);
        checkVal("rst_rvalid", 256'(rValid), 256'(0));
        checkVal("rst_wvalid", 256'(wValid), 256'(0));
        checkVal("rst_rdata", blkRd, '0);
        rstN = 1'b1;

        // Fill lines 0..31 so every later access hits known contents.
        for (int l = 0; l < 32; l++) blkOp(1'b1, 32'(l * 32), randLine(), "init");

        wordWrite(32'h100, 32'hDEADBEEF, 2'd0);
        @(negedge clk); addr = 32'h100; #1; checkVal("w4_rd100", 256'(rData), 256'(32'hDEADBEEF));
        @(negedge clk); addr = 32'h102; #1; checkVal("w4_rd102", 256'(rData), 256'(32'hDEADBEEF));
        wordWrite(32'h101, 32'h000000AA, 2'd1);
        @(negedge clk); addr = 32'h100; #1; checkVal("w1_rd100", 256'(rData), 256'(32'hDEAABEEF));
        wordWrite(32'h103, 32'h00112233, 2'd3);
        @(negedge clk); addr = 32'h100; #1; checkVal("w3_drop", 256'(rData), 256'(32'hDEAABE11));
        wordCheck("w3_next", 32'h104);

        p = randLine();
        blkOp(1'b1, 32'h200, p, "bw200");
        blkOp(1'b0, 32'h200, '0, "br200");
        checkVal("br200_exact", blkRd, p);
        @(negedge clk); addr = 32'h204; #1; checkVal("word204", 256'(rData), 256'(p[223:192]));

        // Simultaneous read and write: write goes first, read follows LAT+3 edges later.
        q = randLine();
        @(negedge clk);
        addr = 32'h40; blkWr = q; blkWrReq = 1'b1; blkRdReq = 1'b1;
        k = 0;
        while (!wValid && k < LAT + 10) begin @(negedge clk); k++; end
        checkVal("both_wlat", 256'(k), 256'(LAT + 2));
        checkVal("both_rlow", 256'(rValid), 256'(0));
        blkWrReq = 1'b0;
        modelBlkWrite(32'h40, q);
        k = 0;
        do begin @(negedge clk); k++; end while (!rValid && k < LAT + 12);
        checkVal("both_rlat", 256'(k), 256'(LAT + 3));
        checkVal("both_rdata", blkRd, q);
        blkRdReq = 1'b0;
        lastRead = q;
        mReads++; mWrites++; mWaits += 2 * (LAT + 1);
        @(negedge clk);
        checkVal("both_pulse", 256'(rValid | wValid), 256'(0));

        // Reset during WAIT of a block write.
        @(negedge clk);
        addr = 32'h300; blkWr = randLine(); blkWrReq = 1'b1;
        repeat (2) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkVal("midrst_wvalid", 256'(wValid), 256'(0));
        checkVal("midrst_rdata", blkRd, '0);
        lastRead = '0;
        mReads = 0; mWrites = 0; mWaits = 0;
        blkWrReq = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        anyV = 0;
        repeat (LAT + 8) begin @(negedge clk); if (rValid || wValid) anyV = 1; end
        checkVal("midrst_novalid", 256'(anyV), 256'(0));
        for (int w = 0; w < 8; w++) wordCheck("midrst_line", 32'(32'h300 + 4 * w));
        blkOp(1'b0, 32'h300, '0, "midrst_read");

        for (int it = 0; it < 60; it++) begin
            a = ($urandom() & 32'hFFFF_8000) | 32'($urandom_range(0, 1023));
            case ($urandom_range(0, 3))
                0: begin
                    wordWrite(a, $urandom(), 2'($urandom_range(0, 3)));
                    wordCheck("rnd_ww", a & 32'hFFFF_FFFC);
                end
                1: wordCheck("rnd_wr", a);
                2: blkOp(1'b1, a, randLine(), "rnd_bw");
                default: begin
                    blkOp(1'b0, a, '0, "rnd_br");
                    wordCheck("rnd_brw", a);
                end
            endcase
        end

        p = randLine();
        blkOpB(1'b1, 32'h8000_0200, p, '0, "l0_bw");
        blkOpB(1'b0, 32'h0000_0200, '0, p, "l0_br");
        @(negedge clk); addrB = 32'h208; #1; checkVal("l0_word", 256'(rDataB), 256'(p[191:160]));

`ifdef DMEM_PERF_CNT_EN
        @(negedge clk);
        checkVal("perf_reads", 256'(perfReads), 256'(mReads));
        checkVal("perf_writes", 256'(perfWrites), 256'(mWrites));
        checkVal("perf_waits", 256'(perfWaits), 256'(mWaits));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
